// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the hazard controller
package cpu_pkg;

    localparam int REG_ADDR_W  = 4;
    localparam int STALL_CNT_W = 16;

    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } ctrl_state_t;

    // A source depends on a destination only if it is really read and is not R0.
    function automatic logic src_match(
        input logic                  used,
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] dst
    );
        return used && (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// rtl/pipe_hazard_ctrl_hazard_detect.sv - ID source vs EX/MEM destination compare
module hazard_detect
    import cpu_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic [REG_ADDR_W-1:0] ex_wr_addr,
    input  logic [REG_ADDR_W-1:0] mem_wr_addr,
    input  logic                  ex_reg_write,
    input  logic                  mem_reg_write,
    input  logic                  ex_mem_to_reg,
    output logic                  load_use,
    output logic                  raw_hazard
);

    logic ex_dep;
    logic mem_dep;

    // ID operand dependencies on in-flight writers; WB is write-before-read so it is not checked.
    always_comb begin
        ex_dep     = ex_reg_write &&
                     (src_match(id_rs_used, id_rs_addr, ex_wr_addr) ||
                      src_match(id_rt_used, id_rt_addr, ex_wr_addr));
        mem_dep    = mem_reg_write &&
                     (src_match(id_rs_used, id_rs_addr, mem_wr_addr) ||
                      src_match(id_rt_used, id_rt_addr, mem_wr_addr));
        load_use   = ex_dep && ex_mem_to_reg;
        raw_hazard = ex_dep || mem_dep;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/halt controller; PIPE_HAZARD_FWD_EN selects forwarding build
module pipe_hazard_ctrl
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_ADDR_W-1:0]  id_rs_addr,
    input  logic [REG_ADDR_W-1:0]  id_rt_addr,
    input  logic                   id_rs_used,
    input  logic                   id_rt_used,
    input  logic [REG_ADDR_W-1:0]  ex_wr_addr,
    input  logic [REG_ADDR_W-1:0]  mem_wr_addr,
    input  logic                   ex_reg_write,
    input  logic                   mem_reg_write,
    input  logic                   ex_mem_to_reg,
    input  logic                   mem_req,
    input  logic                   mem_rdy,
    input  logic                   branch_taken,
    input  logic                   id_hlt,
    input  logic                   wb_hlt,
    output logic                   pc_stall,
    output logic                   if_id_stall,
    output logic                   if_id_flush,
    output logic                   id_ex_stall,
    output logic                   id_ex_flush,
    output logic                   ex_mem_stall,
    output logic                   mem_wb_stall,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    ctrl_state_t state;
    logic        mem_wait;
    logic        load_use;
    logic        id_hazard;

`ifdef PIPE_HAZARD_FWD_EN
    hazard_detect u_hazard_detect (
        .id_rs_addr    (id_rs_addr),
        .id_rt_addr    (id_rt_addr),
        .id_rs_used    (id_rs_used),
        .id_rt_used    (id_rt_used),
        .ex_wr_addr    (ex_wr_addr),
        .mem_wr_addr   (mem_wr_addr),
        .ex_reg_write  (ex_reg_write),
        .mem_reg_write (mem_reg_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .load_use      (load_use),
        .raw_hazard    ()
    );

    // Forwarding covers ALU results; only a load feeding the next instruction must wait.
    assign id_hazard = load_use;
`else
    logic raw_hazard;

    hazard_detect u_hazard_detect (
        .id_rs_addr    (id_rs_addr),
        .id_rt_addr    (id_rt_addr),
        .id_rs_used    (id_rs_used),
        .id_rt_used    (id_rt_used),
        .ex_wr_addr    (ex_wr_addr),
        .mem_wr_addr   (mem_wr_addr),
        .ex_reg_write  (ex_reg_write),
        .mem_reg_write (mem_reg_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .load_use      (load_use),
        .raw_hazard    (raw_hazard)
    );

    // No forwarding: any pending writer of a used source blocks ID.
    assign id_hazard = raw_hazard | load_use;
`endif

    assign mem_wait = mem_req & ~mem_rdy;

    // Zero-latency pipeline controls; freeze beats flush beats bubble, and no register gets both.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        if (state == HALTED || mem_wait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
        end else if (state == DRAIN) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (id_hazard) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    // Halt sequencing FSM plus the saturating stall-cycle counter; halted tracks entry to HALTED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (state != HALTED && pc_stall && stall_cnt != STALL_CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            case (state)
                RUN: begin
                    if (!mem_wait && !branch_taken && id_hlt) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!mem_wait && wb_hlt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  id_rs_addr, id_rt_addr, ex_wr_addr, mem_wr_addr;
    logic        id_rs_used, id_rt_used, ex_reg_write, mem_reg_write, ex_mem_to_reg;
    logic        mem_req, mem_rdy, branch_taken, id_hlt, wb_hlt;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, mem_wb_stall, halted;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: pipeline mode flags and stall cycle tally
    bit m_drain;
    bit m_halted;
    int m_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .ex_wr_addr(ex_wr_addr), .mem_wr_addr(mem_wr_addr),
        .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg),
        .mem_req(mem_req), .mem_rdy(mem_rdy), .branch_taken(branch_taken),
        .id_hlt(id_hlt), .wb_hlt(wb_hlt),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic bit dep(input bit used, input logic [3:0] src, input bit we, input logic [3:0] dst);
        return used && we && src != 0 && src == dst;
    endfunction

    // control vector order: pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem, mem_wb
    function automatic logic [6:0] model_ctl();
        bit ex_hit, mem_hit, hz;
        ex_hit  = dep(id_rs_used, id_rs_addr, ex_reg_write, ex_wr_addr) ||
                  dep(id_rt_used, id_rt_addr, ex_reg_write, ex_wr_addr);
        mem_hit = dep(id_rs_used, id_rs_addr, mem_reg_write, mem_wr_addr) ||
                  dep(id_rt_used, id_rt_addr, mem_reg_write, mem_wr_addr);
`ifdef PIPE_HAZARD_FWD_EN
        hz = ex_hit && ex_mem_to_reg;
`else
        hz = ex_hit || mem_hit;
`endif
        if (m_halted || (mem_req && !mem_rdy)) return 7'b1101011;
        if (m_drain)                           return 7'b1010000;
        if (branch_taken)                      return 7'b0010100;
        if (hz)                                return 7'b1100100;
        return 7'b0000000;
    endfunction

    function automatic logic [6:0] dut_ctl();
        return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_stall};
    endfunction

    task automatic idle_inputs();
        id_rs_addr = 0; id_rt_addr = 0; id_rs_used = 0; id_rt_used = 0;
        ex_wr_addr = 0; mem_wr_addr = 0; ex_reg_write = 0; mem_reg_write = 0;
        ex_mem_to_reg = 0; mem_req = 0; mem_rdy = 1; branch_taken = 0;
        id_hlt = 0; wb_hlt = 0;
    endtask

    // inputs are already applied; check mid-cycle then advance the model at the edge
    task automatic cycle();
        logic [6:0] exp;
        bit         freeze;
        #2;
        exp = model_ctl();
        check("ctl", dut_ctl(), exp);
        check("halted", halted, m_halted);
        check("stall_cnt", stall_cnt, m_cnt);
        freeze = mem_req && !mem_rdy;
        @(posedge clk);
        if (!m_halted) begin
            if (exp[6] && m_cnt < 65535) m_cnt++;
            if (m_drain && !freeze && wb_hlt) begin
                m_halted = 1; m_drain = 0;
            end else if (!m_drain && !freeze && !branch_taken && id_hlt) begin
                m_drain = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        #1;
        m_drain = 0; m_halted = 0; m_cnt = 0;
        check("rst_ctl", dut_ctl(), 7'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_cnt", stall_cnt, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1;
        #2;
        do_reset();

        // load R3 in EX feeding ID rs -> one bubble
        ex_reg_write = 1; ex_mem_to_reg = 1; ex_wr_addr = 3; id_rs_addr = 3; id_rs_used = 1;
        cycle();
        check("lu_ctl", dut_ctl(), 7'b1100100);
        idle_inputs();
        cycle();
        check("lu_cnt", stall_cnt, 16'd1);
        check("lu_clear", dut_ctl(), 7'b0);

        // load to R0 never stalls
        ex_reg_write = 1; ex_mem_to_reg = 1; ex_wr_addr = 0; id_rs_addr = 0; id_rs_used = 1;
        cycle();
        check("r0_ctl", dut_ctl(), 7'b0);
        idle_inputs();

        // memory wait dominates branch for three cycles, branch flushes afterwards
        do_reset();
        mem_req = 1; mem_rdy = 0; branch_taken = 1;
        repeat (3) cycle();
        mem_req = 0; mem_rdy = 1;
        cycle();
        check("mw_cnt", stall_cnt, 16'd3);
        check("br_ctl", dut_ctl(), 7'b0010100);
        idle_inputs();

        // halt with branch: flush only; halt alone drains then halts on wb_hlt
        id_hlt = 1; branch_taken = 1;
        cycle();
        branch_taken = 0;
        cycle();
        id_hlt = 0;
        repeat (3) cycle();
        check("drain_ctl", dut_ctl(), 7'b1010000);
        wb_hlt = 1;
        cycle();
        wb_hlt = 0; branch_taken = 1; mem_rdy = 1;
        cycle();
        check("halt_flag", halted, 1'b1);
        check("halt_ctl", dut_ctl(), 7'b1101011);
        idle_inputs();

        // async reset in the middle of a cycle while draining
        do_reset();
        id_hlt = 1;
        cycle();
        id_hlt = 0;
        cycle();
        cycle();
        #3;
        rst_n = 0;
        #1;
        m_drain = 0; m_halted = 0; m_cnt = 0;
        check("arst_cnt", stall_cnt, 16'd0);
        check("arst_halted", halted, 1'b0);
        check("arst_ctl", dut_ctl(), 7'b0);
        @(posedge clk);
        #1;
        rst_n = 1;

        // ALU result in MEM read by ID: stalls only without forwarding
        mem_reg_write = 1; mem_wr_addr = 5; id_rt_addr = 5; id_rt_used = 1;
        repeat (2) cycle();
`ifdef PIPE_HAZARD_FWD_EN
        check("mem_raw", dut_ctl(), 7'b0);
`else
        check("mem_raw", dut_ctl(), 7'b1100100);
`endif
        mem_reg_write = 0;
        cycle();
        check("mem_raw_clr", dut_ctl(), 7'b0);
        idle_inputs();

        // random traffic against the model; reset whenever the core halts
        for (int i = 0; i < 3000; i++) begin
            id_rs_addr    = 4'($urandom_range(0, 7));
            id_rt_addr    = 4'($urandom_range(0, 7));
            ex_wr_addr    = 4'($urandom_range(0, 7));
            mem_wr_addr   = 4'($urandom_range(0, 7));
            id_rs_used    = 1'($urandom);
            id_rt_used    = 1'($urandom);
            ex_reg_write  = 1'($urandom);
            mem_reg_write = 1'($urandom);
            ex_mem_to_reg = 1'($urandom);
            mem_req       = ($urandom_range(0, 3) == 0);
            mem_rdy       = 1'($urandom);
            branch_taken  = ($urandom_range(0, 4) == 0);
            id_hlt        = ($urandom_range(0, 24) == 0);
            wb_hlt        = ($urandom_range(0, 5) == 0);
            cycle();
            if (m_halted && $urandom_range(0, 3) == 0) do_reset();
        end

        // long memory wait drives the counter to saturation
        do_reset();
        mem_req = 1; mem_rdy = 0;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            if (m_cnt < 65535) m_cnt++;
        end
        #1;
        check("sat_cnt", stall_cnt, m_cnt);
        check("sat_max", stall_cnt, 16'hFFFF);
        cycle();
        check("sat_hold", stall_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
